instruction_fetch: RTL and testbench

Fetch controller sitting on the output side of `Program_Counter`: it consumes `PC`, reads the instruction word from instruction memory, presents it downstream with a valid/ready handshake, and drives `PCe` back to the counter to step to the next address. One outstanding memory read at a time; flush support for branch redirect; timeout detection for a hung memory.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_timer.sv | 45 ++++
 rtl/instruction_fetch.sv | 146 ++++++++++++++
 tb/tb_instruction_fetch.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared state encoding and defaults for the instruction fetch controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fetch_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_REQ   = ST_REQ,
        S_WAIT  = ST_WAIT,
        S_HOLD  = ST_HOLD,
        S_DRAIN = ST_DRAIN,
        S_ERR   = ST_ERR
    } fetch_state_e;

    // Longest wait for a memory response before the read is declared hung.
    localparam int unsigned WAIT_MAX_DEF = 15;

    // Bits needed to hold 0..max_cycles inclusive.
    function automatic int unsigned timer_w(input int unsigned max_cycles);
        return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Saturating wait counter shared by the WAIT and DRAIN states; flags expiry at WAIT_MAX.
// Latency: expired_o is combinational on the count, asserted in the cycle whose increment reaches WAIT_MAX.
// Backpressure: none; counts whenever enabled, clear has priority over counting.
module fetch_timer
    import fetch_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned   TW     = timer_w(WAIT_MAX);
    localparam logic [TW-1:0] MAX_C  = TW'(WAIT_MAX);
    localparam logic [TW-1:0] LAST_C = TW'(WAIT_MAX - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: clear wins, otherwise step up and stick at WAIT_MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The cycle that would carry the count to WAIT_MAX is the last one allowed.
    assign expired_o = en_i && (cnt_q >= LAST_C);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch controller: reads one instruction per PC from memory and hands it downstream; optional FETCH_COUNT_EN adds a fetch counter.
// Latency: REQ, WAIT (>=1 cycle), HOLD -> 3 cycles per word with a 1-cycle memory and instr_ready held high.
// Backpressure: instr_valid/instr_ready; the word is held stable and no new read issues until accepted or flushed.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic [ADDR_W-1:0] PC,
    output logic              PCe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_error
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              rd_q, rd_d;
    logic              pce_q, pce_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              tmr_en;
    logic              tmr_clr;
    logic              tmr_expired;

    // One timer serves both the response wait and the stale-response drain;
    // it restarts from zero on every state change.
    assign tmr_en  = (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign tmr_clr = !tmr_en || (state_d != state_q);

    fetch_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timer (
        .clk       (clk),
        .rst_n     (reset),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // Next state and next registered outputs; flush dominates every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (flush)       state_d = S_IDLE;
                else if (enable) state_d = S_REQ;
            end
            S_REQ: begin
                state_d = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                // A response landing with the flush is consumed here, so no drain is needed.
                if (flush)            state_d = mem_valid ? S_IDLE : S_DRAIN;
                else if (mem_valid)   state_d = S_HOLD;
                else if (tmr_expired) state_d = S_ERR;
            end
            S_HOLD: begin
                if (flush)            state_d = S_IDLE;
                else if (instr_ready) state_d = enable ? S_REQ : S_IDLE;
            end
            S_DRAIN: begin
                if (flush || mem_valid || tmr_expired) state_d = S_IDLE;
            end
            S_ERR: begin
                if (flush) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        addr_d  = (state_q == S_REQ) ? PC : addr_q;
        instr_d = ((state_q == S_WAIT) && mem_valid && !flush) ? mem_rdata : instr_q;
        rd_d    = (state_d == S_REQ);
        pce_d   = (state_d == S_HOLD) && (state_q != S_HOLD);
        valid_d = (state_d == S_HOLD);
        err_d   = (state_d == S_ERR);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs and the captured request address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            instr_q <= '0;
            rd_q    <= 1'b0;
            pce_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            instr_q <= instr_d;
            rd_q    <= rd_d;
            pce_q   <= pce_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Live PC during the request cycle so the read goes out the same cycle REQ is entered.
    assign mem_addr    = (state_q == S_REQ) ? PC : addr_q;
    assign mem_rd      = rd_q;
    assign PCe         = pce_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign fetch_error = err_q;

`ifdef FETCH_COUNT_EN
    logic [15:0] fcnt_q;

    // Counts PC increments; wraps naturally and survives flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt_q <= '0;
        end else if (pce_q) begin
            fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign fetch_count = fcnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: memory responds 1..4 cycles after each read (or never, for the timeout case).
// Backpressure: instr_ready is randomized; a word must stay put until it is taken.
module tb_instruction_fetch;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int WMAX = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          flush;
    logic [AW-1:0] PC;
    logic          PCe;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          fetch_error;
`ifdef FETCH_COUNT_EN
    logic [15:0]   fetch_count;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .WAIT_MAX (WMAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .flush       (flush),
        .PC          (PC),
        .PCe         (PCe),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_error (fetch_error)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory / program-counter model state.
    int          cyc      = 0;
    bit          chk_en   = 1'b0;
    bit          outst    = 1'b0;   // a read is in flight (response not yet seen)
    bit          live     = 1'b0;   // that read has not been flushed
    int          due      = -1;     // cycle its response is driven
    logic [15:0] req_dat  = '0;
    int          lat_mode = 1;      // >0 fixed latency, 0 never respond, <0 random 1..4
    bit          ovr_en   = 1'b0;
    logic [15:0] ovr_dat  = '0;
    logic [15:0] pc       = '0;
    int          n_pce     = 0;
    int          n_present = 0;

    // Expectations for the next cycle.
    bit          exp_valid = 1'b0;
    bit          exp_pce   = 1'b0;
    bit          exp_rd    = 1'b0;
    logic [15:0] exp_instr = '0;

    // Outputs sampled this cycle.
    bit          s_rd, s_valid, s_pce, s_err;
    logic [15:0] s_addr, s_instr;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    // One clock: sample outputs mid-cycle, check them, then drive this cycle's inputs
    // and derive what the next cycle must show.
    task automatic step(input bit en, input bit rdy, input bit fl);
        bit resp;
        bit idle;
        bit present;
        int lat;
        @(negedge clk);
        cyc++;
        s_rd = mem_rd; s_addr = mem_addr; s_valid = instr_valid;
        s_instr = instr; s_pce = PCe; s_err = fetch_error;
        if (chk_en) begin
            check_eq("instr_valid", s_valid, exp_valid);
            check_eq("pce", s_pce, exp_pce);
            check_eq("mem_rd", s_rd, exp_rd);
            check_eq("fetch_error", s_err, 0);
            if (exp_valid) check_eq("instr", s_instr, exp_instr);
            if (s_rd) check_eq("rd_addr", s_addr, pc);
        end
        if (s_pce) begin
            n_pce++;
            pc = pc + 16'd1;
            PC = pc;
        end
        enable = en; instr_ready = rdy; flush = fl;
        resp      = outst && (due == cyc);
        mem_valid = resp;
        mem_rdata = resp ? req_dat : 16'($urandom);
        idle      = !s_rd && !s_valid && !outst;
        present   = resp && live && !fl;
        exp_valid = present || (s_valid && !rdy && !fl);
        exp_pce   = present;
        exp_instr = present ? req_dat : s_instr;
        exp_rd    = !fl && en && (idle || (s_valid && rdy));
        if (present) n_present++;
        if (resp) outst = 1'b0;
        if (fl) live = 1'b0;
        if (s_rd) begin
            lat     = (lat_mode < 0) ? int'($urandom_range(1, 4)) : lat_mode;
            outst   = 1'b1;
            live    = !fl;
            req_dat = ovr_en ? ovr_dat : mem_word(s_addr);
            ovr_en  = 1'b0;
            due     = (lat == 0) ? -1 : cyc + lat;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pce_cyc[$];
        logic [15:0] pce_ins[$];
        bit          found;
        logic [15:0] held;
        int          nv, np, cnt;
        bit          rd5, err15, err16, rd16;
        logic [15:0] a5;

        reset = 1'b0; enable = 1'b0; flush = 1'b0; instr_ready = 1'b0;
        mem_valid = 1'b0; mem_rdata = '0; PC = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_pce", PCe, 0);
        check_eq("rst_mem_rd", mem_rd, 0);
        check_eq("rst_instr_valid", instr_valid, 0);
        check_eq("rst_fetch_error", fetch_error, 0);
        check_eq("rst_instr", instr, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        reset = 1'b1;
        step(1, 1, 0);
        chk_en = 1'b1;

        // Back-to-back fetch with 1-cycle memory: 0x1000, 0x1001, ... every 3 cycles.
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0);
            if (s_pce) begin
                pce_cyc.push_back(cyc);
                pce_ins.push_back(s_instr);
            end
        end
        check_eq("loop_words", pce_cyc.size() >= 3, 1);
        if (pce_cyc.size() >= 3) begin
            for (int k = 0; k < 3; k++) check_eq("loop_instr", pce_ins[k], 16'h1000 + 16'(k));
            for (int k = 1; k < 3; k++) check_eq("loop_period", pce_cyc[k] - pce_cyc[k-1], 3);
        end

        // Downstream stall: word and valid held, one PCe, no new read.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0, 0);
            found = s_valid;
        end
        check_eq("hold_seen", found, 1);
        check_eq("hold_first_pce", s_pce, 1);
        held = s_instr;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0);
            check_eq("hold_valid", s_valid, 1);
            check_eq("hold_instr", s_instr, held);
            check_eq("hold_no_pce", s_pce, 0);
            check_eq("hold_no_rd", s_rd, 0);
        end

        // Flush in WAIT, stale 0xDEAD arrives two cycles later and must vanish.
        lat_mode = 3; ovr_en = 1'b1; ovr_dat = 16'hDEAD;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 1, 0);
            found = s_rd;
        end
        check_eq("drain_req_seen", found, 1);
        lat_mode = 1;
        step(1, 1, 1);
        nv = 0; np = 0; rd5 = 1'b0; a5 = '0;
        for (int i = 2; i <= 5; i++) begin
            step(1, 1, 0);
            nv += int'(s_valid);
            np += int'(s_pce);
            if (i == 5) begin
                rd5 = s_rd;
                a5  = s_addr;
            end
        end
        check_eq("drain_no_valid", nv, 0);
        check_eq("drain_no_pce", np, 0);
        check_eq("drain_next_req", rd5, 1);
        check_eq("drain_next_addr", a5, pc);

        // Flush together with the response: dropped, back to idle.
        lat_mode = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 1, 0);
            found = s_rd;
        end
        check_eq("fv_req_seen", found, 1);
        lat_mode = 1;
        step(1, 1, 0);
        step(1, 1, 1);
        step(1, 1, 0);
        check_eq("fv_valid", s_valid, 0);
        check_eq("fv_pce", s_pce, 0);
        check_eq("fv_rd", s_rd, 0);

        // Hung memory: error after WAIT_MAX wait cycles, cleared by flush.
        chk_en = 1'b0; lat_mode = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 1, 0);
            found = s_rd;
        end
        check_eq("to_req_seen", found, 1);
        np = 0; err15 = 1'b1; err16 = 1'b0; rd16 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 0);
            np += int'(s_pce);
            if (i == 15) err15 = s_err;
            if (i == 16) begin
                err16 = s_err;
                rd16  = s_rd;
            end
        end
        check_eq("to_err_before", err15, 0);
        check_eq("to_err_set", err16, 1);
        check_eq("to_no_rd", rd16, 0);
        check_eq("to_no_pce", np, 0);
        step(0, 1, 1);
        outst = 1'b0; live = 1'b0; due = -1; lat_mode = 1;
        chk_en = 1'b1;
        step(1, 1, 0);
        check_eq("to_flush_clear", s_err, 0);

        // Randomized traffic; a second flush is withheld while a killed read is in flight.
        lat_mode = -1;
        for (int i = 0; i < 1500; i++) begin
            bit fl;
            fl = ($urandom_range(0, 19) == 0) && !(outst && !live);
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, fl);
        end
        check_eq("pce_total", n_pce, n_present);

        // Reset in the middle of a wait.
        chk_en = 1'b0; lat_mode = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1, 1, 0);
            found = s_rd;
        end
        check_eq("mid_req_seen", found, 1);
        step(1, 1, 0);
        #2 reset = 1'b0;
        #1;
        check_eq("mid_pce", PCe, 0);
        check_eq("mid_mem_rd", mem_rd, 0);
        check_eq("mid_instr_valid", instr_valid, 0);
        check_eq("mid_fetch_error", fetch_error, 0);
        check_eq("mid_instr", instr, 0);
        check_eq("mid_mem_addr", mem_addr, 0);
`ifdef FETCH_COUNT_EN
        check_eq("mid_fetch_count", fetch_count, 0);
`endif
        @(posedge clk);
        #2 reset = 1'b1;
        outst = 1'b0; live = 1'b0; due = -1; lat_mode = 1;
        step(1, 1, 0);
        chk_en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 3; i++) begin
            step(1, 1, 0);
            cnt += int'(s_pce);
        end
        check_eq("post_rst_fetches", cnt, 3);
        step(0, 1, 0);
`ifdef FETCH_COUNT_EN
        check_eq("fetch_count", fetch_count, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
